// File: rtl/uarc_io_pkg.sv
// Shared I/O definitions for the uarc core's character devices.
// Holds the ASCII code type and the memory-mapped stdin/stdout addresses.
package uarc_io_pkg;

  localparam int WORD_MAG = 5;

  typedef logic [6:0] ascii_t;

  localparam ascii_t ASCII_NUL = 7'h00;

  localparam logic [31:0] STDIN_ADDR  = 32'h8000_0000;
  localparam logic [31:0] STDOUT_ADDR = 32'h8000_0001;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and an asynchronous register read.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
  parameter int WIDTH     = 7,
  parameter int DEPTH_MAG = 4
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   head,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_MAG:0] count
);

  localparam int DEPTH = 1 << DEPTH_MAG;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [DEPTH_MAG:0] wptr_q, wptr_d;
  logic [DEPTH_MAG:0] rptr_q, rptr_d;
  logic               do_push;
  logic               do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_MAG] != rptr_q[DEPTH_MAG]) &&
                 (wptr_q[DEPTH_MAG-1:0] == rptr_q[DEPTH_MAG-1:0]);
  assign count = wptr_q - rptr_q;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem_q[rptr_q[DEPTH_MAG-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[DEPTH_MAG-1:0]] = din;
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/kbd_rx_fifo.sv
// Keyboard receive stage: buffers ASCII codes from ps2_ascii and hands them to core0.
// Handshake: rx_send is valid, rx_send_ack is ready; a character transfers on a cycle where both are high.
module kbd_rx_fifo
  import uarc_io_pkg::*;
#(
  parameter int WORD_MAG       = uarc_io_pkg::WORD_MAG,
  parameter int DEPTH_MAG      = 4,
  parameter int DROP_CNT_WIDTH = 8,
  parameter int DROP_NUL       = 1
) (
  input  logic                        clk,
  input  logic                        reset_b,
  input  logic                        new_code,
  input  logic [6:0]                  ascii_code,
  input  logic                        rx_enable,
  output logic                        rx_send,
  input  logic                        rx_send_ack,
  output logic [(1<<WORD_MAG)-1:0]    rx_data,
  output logic [DEPTH_MAG:0]          fifo_count,
  output logic                        overflow,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count,
  input  logic                        overflow_clear
);

  localparam int WORD_WIDTH = 1 << WORD_MAG;

  ascii_t                      head;
  logic                        full;
  logic                        empty;
  logic                        push_req;
  logic                        pop;
  logic                        drop;
  logic                        overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
  logic [DROP_CNT_WIDTH-1:0]   drop_base;

  assign push_req = new_code && !((DROP_NUL != 0) && (ascii_code == ASCII_NUL));
  assign rx_send  = rx_enable && !empty;
  assign pop      = rx_send && rx_send_ack;
  assign drop     = push_req && full && !pop;

  sync_fifo #(
    .WIDTH     ($bits(ascii_t)),
    .DEPTH_MAG (DEPTH_MAG)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (push_req),
    .pop     (pop),
    .din     (ascii_code),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign rx_data = {{(WORD_WIDTH-7){1'b0}}, head};

  // A clear and a drop in the same cycle leave the flag set and the counter at one.
  always_comb begin
    drop_base    = overflow_clear ? '0 : drop_count_q;
    overflow_d   = overflow_clear ? 1'b0 : overflow_q;
    drop_count_d = drop_base;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_base != {DROP_CNT_WIDTH{1'b1}}) begin
        drop_count_d = drop_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/kbd_rx_fifo.md
# kbd_rx_fifo

Keyboard receive stage between `ps2_ascii` and core0's receiver bus 0. It replaces the single-character latch with a power-of-two FIFO of 7-bit ASCII codes and presents the head entry to the core as a zero-extended word under the receiver send/ack handshake. Characters that arrive while the FIFO is full are dropped and counted. The block has one clock and no other clock-domain logic.

## Interface
Parameters:
- `WORD_MAG`, default 5: log2 of the core word width; `WORD_WIDTH = 1 << WORD_MAG`.
- `DEPTH_MAG`, default 4: log2 of FIFO depth, so 16 entries by default. Must be at least 1.
- `DROP_CNT_WIDTH`, default 8: width of the saturating drop counter.
- `DROP_NUL`, default 1: when 1, codes equal to 7'h00 are discarded and never stored.

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `reset_b`, in, 1: reset, synchronous, active-low.
- `new_code`, in, 1: one-cycle strobe from `ps2_ascii`.
- `ascii_code`, in, 7: character qualified by `new_code`.
- `rx_enable`, in, 1: receiver bus enable from top level.
- `rx_send`, out, 1: head character valid toward core0.
- `rx_send_ack`, in, 1: core0 accepts the head this cycle.
- `rx_data`, out, WORD_WIDTH: head character, `{{WORD_WIDTH-7{1'b0}}, head}`.
- `fifo_count`, out, DEPTH_MAG+1: current occupancy, 0 to 2^DEPTH_MAG.
- `overflow`, out, 1: sticky flag, set by any dropped character.
- `drop_count`, out, DROP_CNT_WIDTH: dropped characters; saturates at all-ones.
- `overflow_clear`, in, 1: one-cycle pulse that clears `overflow` and `drop_count`.

## Operation
- Qualifiers:
  - `push_req = new_code && !(DROP_NUL && ascii_code == 0)`.
  - `pop = rx_send && rx_send_ack`.
- Push succeeds when `push_req && (!full || pop)`. Pushing into a full FIFO in the same cycle as a pop is therefore legal; the count is unchanged.
- Drop occurs when `push_req && full && !pop`. The FIFO is untouched, `overflow` is set to 1 and `drop_count` increments unless it is saturated.
- `rx_send = rx_enable && !empty`. It is combinational from registered state.
- `rx_data` is first-word-fall-through: it always shows the head entry.
  - It must hold stable while `rx_send` is high and no ack arrives.
  - It shows 0 when the FIFO is empty.
- `rx_send_ack` while `rx_send` is low is ignored; there is no pop.
- Deasserting `rx_enable` stalls delivery and keeps the contents. Pushes continue.
- Simultaneous push and pop:
  - Count is unchanged.
  - Order is preserved; the new entry goes behind existing ones.
  - On an empty FIFO, a push cannot coincide with a pop because `rx_send` is 0.
- `overflow_clear` together with a drop in the same cycle: the drop wins. `overflow` = 1 and `drop_count` = 1.
- Pointers:
  - Read and write pointers are DEPTH_MAG+1 bits wide and wrap modulo 2^(DEPTH_MAG+1).
  - `full` is MSBs differing with the lower bits equal.
  - `empty` is the pointers being equal.
  - `fifo_count = wptr - rptr` in DEPTH_MAG+1 bits.

## Timing
- Reset is sampled on `clk` while `reset_b` = 0. The cycle after that:
  - the FIFO is empty (pointers 0);
  - `rx_send` = 0, `rx_data` = 0, `fifo_count` = 0, `overflow` = 0, `drop_count` = 0.
- Reset in the middle of operation discards all stored characters. A `new_code` that coincides with reset is lost.
- Latency: a `new_code` at edge N gives `rx_send` = 1 and valid `rx_data` in the cycle after edge N, provided the FIFO was empty and `rx_enable` = 1.
- Pop latency: an ack at edge N advances the head visible after N. Back-to-back acks drain one entry per cycle.
- Storage is registers or LUTRAM with an asynchronous read. The read is not a registered read, so no extra latency is added.

## Structure
- Shared package `uarc_io_pkg`:
  - `WORD_MAG` default;
  - `ascii_t` (logic [6:0]);
  - constant `ASCII_NUL`;
  - constants `STDIN_ADDR` = 32'h8000_0000 and `STDOUT_ADDR` = 32'h8000_0001, for the later bus decoder.
- Sub-module `sync_fifo`:
  - parameterised by width and DEPTH_MAG;
  - push/pop/full/empty/count, with first-word-fall-through head;
  - reusable later for the VGA output stage.
- `kbd_rx_fifo` itself holds the filter, drop logic, counter and handshake.

## Test plan
- Reset, then one `new_code` with 7'h41 and `rx_enable` = 1, ack held low → one cycle later `rx_send` = 1, `rx_data` = 32'h41, `fifo_count` = 1, held for 10 cycles. Then ack once → `rx_send` = 0 and `fifo_count` = 0 the next cycle.
- Push 'a', 'b', 'c' on consecutive cycles, then hold ack high → `rx_data` goes 0x61, 0x62, 0x63 on three consecutive cycles, then `rx_send` = 0.
- Fill 16 entries, then push 3 more with no ack → `fifo_count` = 16, `overflow` = 1, `drop_count` = 3. Drain 16 → the original order is intact.
- With the FIFO full, push while acking in the same cycle → `fifo_count` stays 16 and `drop_count` is unchanged. The pushed character emerges last.
- With `DROP_NUL` = 1, push 7'h00 → `fifo_count` stays 0. With 2 entries stored, `rx_enable` = 0 for 5 cycles → `rx_send` = 0 and the count stays 2.
- Force 300 drops → `drop_count` = 8'hFF. Then `overflow_clear` in the same cycle as a drop → `overflow` = 1 and `drop_count` = 1. Assert reset mid-stream → all outputs are 0 the next cycle.
